rvv_profiler: RTL and testbench

- Cycle-accurate performance profiler for the RVV benchmark SoC. Instantiated beside the test harness inside the simulation top.
- Accumulates per-region cycle, instruction, vector-instruction and vector-busy counts between software start/stop markers.
- Exposes the counts through a registered read port so the bench can dump them at end of test.

---
 rtl/rvv_profiler_pkg.sv | 31 +++
 rtl/sat_counter.sv | 32 +++
 rtl/rvv_profiler.sv | 138 +++++++++++++
 tb/tb_rvv_profiler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_profiler_pkg.sv
// rtl/rvv_profiler_pkg.sv - shared read-select encoding and per-event counter-set type
package rvv_profiler_pkg;

    localparam logic [1:0] SEL_CYCLES   = 2'd0;
    localparam logic [1:0] SEL_INSTRET  = 2'd1;
    localparam logic [1:0] SEL_VINSTRET = 2'd2;
    localparam logic [1:0] SEL_VBUSY    = 2'd3;

    // One increment request per counter of a region; bit position equals the rd_sel code.
    typedef struct packed {
        logic vbusy;
        logic vinstret;
        logic instret;
        logic cycles;
    } cnt_set_t;

    // Translate the retire/busy observations of one cycle into per-counter increments.
    function automatic cnt_set_t event_set(
        input logic retire_valid,
        input logic retire_vec,
        input logic vec_busy
    );
        cnt_set_t s;
        s.cycles   = 1'b1;
        s.instret  = retire_valid;
        s.vinstret = retire_valid & retire_vec;
        s.vbusy    = vec_busy;
        return s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating counter with clear priority and sticky overflow flag
module sat_counter #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         ovf
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Clear wins over increment; at all-ones the value holds and the wrap is remembered.
    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (&value) begin
                ovf <= 1'b1;
            end else begin
                value <= value + ONE;
            end
        end
    end

endmodule

// File: rtl/rvv_profiler.sv
// rtl/rvv_profiler.sv - per-region cycle/instruction/vector profiler with registered read port
module rvv_profiler
    import rvv_profiler_pkg::*;
#(
    parameter  int NUM_REGIONS = 8,
    parameter  int CNT_W       = 64,
    localparam int ID_W        = $clog2(NUM_REGIONS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   retire_valid,
    input  logic                   retire_vec,
    input  logic                   vec_busy,
    input  logic                   mark_valid,
    input  logic                   mark_start,
    input  logic [ID_W-1:0]        mark_id,
    input  logic                   clr_valid,
    input  logic [ID_W-1:0]        clr_id,
    input  logic                   rd_en,
    input  logic [ID_W-1:0]        rd_id,
    input  logic [1:0]             rd_sel,
    output logic                   rd_valid,
    output logic [CNT_W-1:0]       rd_data,
    output logic [NUM_REGIONS-1:0] active,
    output logic [NUM_REGIONS-1:0] overflow,
    output logic [CNT_W-1:0]       global_cycles
);

    cnt_set_t               ev;
    logic [NUM_REGIONS-1:0] cnt_en;
    logic [NUM_REGIONS-1:0] clr_hit;

    logic [CNT_W-1:0]       cyc_q [NUM_REGIONS];
    logic [CNT_W-1:0]       ins_q [NUM_REGIONS];
    logic [CNT_W-1:0]       vin_q [NUM_REGIONS];
    logic [CNT_W-1:0]       vbu_q [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] ovf_cyc;
    logic [NUM_REGIONS-1:0] ovf_ins;
    logic [NUM_REGIONS-1:0] ovf_vin;
    logic [NUM_REGIONS-1:0] ovf_vbu;

    logic [CNT_W-1:0]       rd_word;
    logic                   unused_global_ovf;

    assign ev     = event_set(retire_valid, retire_vec, vec_busy);
    // Counting uses the flags registered before this edge, so a start marker's own cycle is skipped.
    assign cnt_en = en ? active : '0;

    // Decode the clear strobe into a one-hot region select.
    always_comb begin
        clr_hit = '0;
        if (clr_valid) begin
            clr_hit[clr_id] = 1'b1;
        end
    end

    // Marker updates the targeted region's flag; repeated start/stop are naturally idempotent.
    always_ff @(posedge clock) begin
        if (reset) begin
            active <= '0;
        end else if (mark_valid) begin
            active[mark_id] <= mark_start;
        end
    end

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
        sat_counter #(.W(CNT_W)) u_cycles (
            .clock (clock),
            .reset (reset),
            .inc   (cnt_en[r] & ev.cycles),
            .clr   (clr_hit[r]),
            .value (cyc_q[r]),
            .ovf   (ovf_cyc[r])
        );
        sat_counter #(.W(CNT_W)) u_instret (
            .clock (clock),
            .reset (reset),
            .inc   (cnt_en[r] & ev.instret),
            .clr   (clr_hit[r]),
            .value (ins_q[r]),
            .ovf   (ovf_ins[r])
        );
        sat_counter #(.W(CNT_W)) u_vinstret (
            .clock (clock),
            .reset (reset),
            .inc   (cnt_en[r] & ev.vinstret),
            .clr   (clr_hit[r]),
            .value (vin_q[r]),
            .ovf   (ovf_vin[r])
        );
        sat_counter #(.W(CNT_W)) u_vbusy (
            .clock (clock),
            .reset (reset),
            .inc   (cnt_en[r] & ev.vbusy),
            .clr   (clr_hit[r]),
            .value (vbu_q[r]),
            .ovf   (ovf_vbu[r])
        );
    end

    assign overflow = ovf_cyc | ovf_ins | ovf_vin | ovf_vbu;

    sat_counter #(.W(CNT_W)) u_global (
        .clock (clock),
        .reset (reset),
        .inc   (en),
        .clr   (1'b0),
        .value (global_cycles),
        .ovf   (unused_global_ovf)
    );

    // Select the requested counter from the pre-edge values.
    always_comb begin
        rd_word = '0;
        case (rd_sel)
            SEL_CYCLES:   rd_word = cyc_q[rd_id];
            SEL_INSTRET:  rd_word = ins_q[rd_id];
            SEL_VINSTRET: rd_word = vin_q[rd_id];
            SEL_VBUSY:    rd_word = vbu_q[rd_id];
            default:      rd_word = '0;
        endcase
    end

    // One-cycle read pipeline; data holds between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_rvv_profiler.sv
// tb/tb_rvv_profiler.sv - randomized and directed self-checking bench for rvv_profiler
module tb_rvv_profiler;

    localparam int NR   = 8;
    localparam int CW   = 8;
    localparam int IDW  = 3;
    localparam int MAXV = (1 << CW) - 1;

    logic           clock = 1'b0;
    logic           reset;
    logic           en;
    logic           retire_valid;
    logic           retire_vec;
    logic           vec_busy;
    logic           mark_valid;
    logic           mark_start;
    logic [IDW-1:0] mark_id;
    logic           clr_valid;
    logic [IDW-1:0] clr_id;
    logic           rd_en;
    logic [IDW-1:0] rd_id;
    logic [1:0]     rd_sel;
    logic           rd_valid;
    logic [CW-1:0]  rd_data;
    logic [NR-1:0]  active;
    logic [NR-1:0]  overflow;
    logic [CW-1:0]  global_cycles;

    always #5 clock = ~clock;

    rvv_profiler #(.NUM_REGIONS(NR), .CNT_W(CW)) dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
        .retire_valid  (retire_valid),
        .retire_vec    (retire_vec),
        .vec_busy      (vec_busy),
        .mark_valid    (mark_valid),
        .mark_start    (mark_start),
        .mark_id       (mark_id),
        .clr_valid     (clr_valid),
        .clr_id        (clr_id),
        .rd_en         (rd_en),
        .rd_id         (rd_id),
        .rd_sel        (rd_sel),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .active        (active),
        .overflow      (overflow),
        .global_cycles (global_cycles)
    );

    int m_cnt [NR][4];
    bit m_act [NR];
    bit m_ovf [NR];
    int m_glob;
    bit m_rdv;
    int m_rdd;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit [3:0] ev;
        if (reset) begin
            for (int r = 0; r < NR; r++) begin
                for (int k = 0; k < 4; k++) m_cnt[r][k] = 0;
                m_act[r] = 0;
                m_ovf[r] = 0;
            end
            m_glob = 0;
            m_rdv  = 0;
            m_rdd  = 0;
        end else begin
            ev[0] = 1'b1;
            ev[1] = retire_valid;
            ev[2] = retire_valid && retire_vec;
            ev[3] = vec_busy;
            m_rdv = rd_en;
            if (rd_en) m_rdd = m_cnt[rd_id][rd_sel];
            for (int r = 0; r < NR; r++) begin
                if (en && m_act[r]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (ev[k]) begin
                            if (m_cnt[r][k] == MAXV) m_ovf[r] = 1;
                            else m_cnt[r][k] = m_cnt[r][k] + 1;
                        end
                    end
                end
            end
            if (en && m_glob < MAXV) m_glob = m_glob + 1;
            if (clr_valid) begin
                for (int k = 0; k < 4; k++) m_cnt[clr_id][k] = 0;
                m_ovf[clr_id] = 0;
            end
            if (mark_valid) m_act[mark_id] = mark_start;
        end
    endtask

    task automatic tick();
        logic [NR-1:0] ea;
        logic [NR-1:0] eo;
        @(posedge clock);
        model_edge();
        #1;
        for (int r = 0; r < NR; r++) begin
            ea[r] = m_act[r];
            eo[r] = m_ovf[r];
        end
        check("active", active, ea);
        check("overflow", overflow, eo);
        check("global_cycles", global_cycles, m_glob);
        check("rd_valid", rd_valid, m_rdv);
        check("rd_data", rd_data, m_rdd);
    endtask

    task automatic idle();
        reset        = 1'b0;
        en           = 1'b1;
        retire_valid = 1'b0;
        retire_vec   = 1'b0;
        vec_busy     = 1'b0;
        mark_valid   = 1'b0;
        mark_start   = 1'b0;
        mark_id      = '0;
        clr_valid    = 1'b0;
        clr_id       = '0;
        rd_en        = 1'b0;
        rd_id        = '0;
        rd_sel       = '0;
    endtask

    task automatic mark(input int id, input bit start);
        mark_valid = 1'b1;
        mark_start = start;
        mark_id    = IDW'(id);
    endtask

    task automatic read_expect(input int id, input int sel, input int exp, input string tag);
        rd_en  = 1'b1;
        rd_id  = IDW'(id);
        rd_sel = 2'(sel);
        tick();
        rd_en  = 1'b0;
        check(tag, rd_data, exp);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Free run: nothing active, global advances.
        repeat (10) tick();
        check("glob_after_10", global_cycles, 10);
        check("active_idle", active, 0);
        for (int r = 0; r < NR; r++) read_expect(r, r % 4, 0, "idle_region_zero");

        // Region 2: start at cycle 0, stop at cycle 5, retire every cycle.
        for (int i = 0; i <= 5; i++) begin
            idle();
            retire_valid = 1'b1;
            retire_vec   = i[0];
            if (i == 0) mark(2, 1'b1);
            if (i == 5) mark(2, 1'b0);
            tick();
        end
        idle();
        read_expect(2, 0, 5, "r2_cycles");
        read_expect(2, 1, 5, "r2_instret");
        read_expect(2, 2, 3, "r2_vinstret");
        read_expect(2, 3, 0, "r2_vbusy");
        read_expect(3, 0, 0, "r3_untouched");

        // Overlapping regions 0 and 1 with the vector unit busy through cycle 8.
        for (int i = 0; i <= 9; i++) begin
            idle();
            vec_busy = (i <= 8);
            if (i == 0) mark(0, 1'b1);
            if (i == 3) mark(1, 1'b1);
            if (i == 8) mark(1, 1'b0);
            if (i == 9) mark(0, 1'b0);
            tick();
        end
        idle();
        read_expect(0, 3, 8, "r0_vbusy");
        read_expect(1, 3, 5, "r1_vbusy");

        // Drive region 3 into saturation, then clear it while still active.
        mark(3, 1'b1);
        tick();
        idle();
        repeat (260) tick();
        read_expect(3, 0, MAXV, "r3_saturated");
        check("r3_ovf_set", overflow[3], 1'b1);
        clr_valid = 1'b1;
        clr_id    = 3'd3;
        tick();
        idle();
        read_expect(3, 0, 0, "r3_cleared_cycles");
        check("r3_ovf_cleared", overflow[3], 1'b0);
        check("r3_still_active", active[3], 1'b1);
        read_expect(3, 1, 0, "r3_cleared_instret");
        mark(3, 1'b0);
        tick();
        idle();

        // Restart of an already-active region keeps accumulating.
        mark(1, 1'b1);
        tick();
        idle();
        repeat (3) tick();
        mark(1, 1'b1);
        tick();
        idle();
        repeat (2) tick();
        mark(1, 1'b0);
        tick();
        idle();
        read_expect(1, 0, 12, "r1_restart_cycles");

        // Back-to-back reads.
        rd_en = 1'b1; rd_id = 3'd0; rd_sel = 2'd3;
        tick();
        check("b2b_valid0", rd_valid, 1'b1);
        check("b2b_data0", rd_data, 8);
        rd_id = 3'd1; rd_sel = 2'd0;
        tick();
        check("b2b_valid1", rd_valid, 1'b1);
        check("b2b_data1", rd_data, 12);
        rd_en = 1'b0;
        tick();
        check("b2b_valid_drop", rd_valid, 1'b0);
        check("b2b_data_hold", rd_data, 12);

        // Four cycles of en=0 inside region 4.
        for (int i = 0; i <= 10; i++) begin
            idle();
            en = !(i >= 3 && i <= 6);
            if (i == 0) mark(4, 1'b1);
            if (i == 10) mark(4, 1'b0);
            tick();
        end
        idle();
        read_expect(4, 0, 6, "r4_en_gated");

        // Randomized traffic against the reference model, with one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            idle();
            reset        = (i == 200);
            en           = ($urandom_range(9) != 0);
            retire_valid = $urandom_range(1);
            retire_vec   = $urandom_range(1);
            vec_busy     = $urandom_range(1);
            mark_valid   = ($urandom_range(5) == 0);
            mark_start   = $urandom_range(1);
            mark_id      = IDW'($urandom_range(NR - 1));
            clr_valid    = ($urandom_range(31) == 0);
            clr_id       = IDW'($urandom_range(NR - 1));
            rd_en        = $urandom_range(1);
            rd_id        = IDW'($urandom_range(NR - 1));
            rd_sel       = 2'($urandom_range(3));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
